// File: rtl/team_06_echo_ctrl_if.sv
// Echo controller bus: effect-side sample/search signals and the sample RAM request port.
// The controller takes the master modport; the effect/RAM environment takes the slave modport.
interface team_06_echo_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              sample_tick;
  logic              search;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] save_audio;
  logic [DATA_W-1:0] past_output;
  logic              search_enable;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              busy;
  logic              overrun;

  modport master (
    input  sample_tick, search, offset, save_audio, mem_rdata, mem_ack,
    output past_output, search_enable, mem_req, mem_we, mem_addr, mem_wdata, busy, overrun
  );

  modport slave (
    output sample_tick, search, offset, save_audio, mem_rdata, mem_ack,
    input  past_output, search_enable, mem_req, mem_we, mem_addr, mem_wdata, busy, overrun
  );
endinterface

// File: rtl/team_06_echo_ctrl.sv
// Echo delay-buffer sequencer: writes each tick's sample to a circular RAM buffer, then
// optionally reads the sample `offset` back; ticks arriving while busy are dropped.
module team_06_echo_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input logic                clk,
  input logic                rst,
  team_06_echo_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [ADDR_W-1:0] FILL_MAX = '1;
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill;
  logic [ADDR_W-1:0] offset_q;
  logic              search_q;
  logic              no_history;

  // Offset 0 or reaching past the stored history yields silence without a RAM read.
  assign no_history = (offset_q == '0) || (offset_q > fill);
  assign bus.busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      fill              <= '0;
      offset_q          <= '0;
      search_q          <= 1'b0;
      bus.past_output   <= '0;
      bus.search_enable <= 1'b0;
      bus.mem_req       <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
      bus.overrun       <= 1'b0;
    end else begin
      bus.overrun       <= bus.sample_tick && (state != IDLE);
      bus.search_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sample_tick) begin
            search_q      <= bus.search;
            offset_q      <= bus.offset;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= wr_ptr;
            bus.mem_wdata <= bus.save_audio;
            state         <= WRITE;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            wr_ptr        <= wr_ptr + ONE;
            if (fill != FILL_MAX) fill <= fill + ONE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            if (!search_q) begin
              state <= IDLE;
            end else if (no_history) begin
              bus.past_output   <= '0;
              bus.search_enable <= 1'b1;
              state             <= DONE;
            end else begin
              // Read address uses the pre-increment pointer, modulo buffer depth.
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= wr_ptr - offset_q;
              state        <= READ;
            end
          end
        end
        READ: begin
          if (bus.mem_ack) begin
            bus.past_output   <= bus.mem_rdata;
            bus.search_enable <= 1'b1;
            bus.mem_req       <= 1'b0;
            bus.mem_addr      <= '0;
            state             <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_team_06_echo_ctrl.sv
// Bench for team_06_echo_ctrl: table of tick vectors against a behavioural RAM responder,
// plus hand sequences for async reset, ack stalls with a dropped tick, and pointer wrap.
module tb_team_06_echo_ctrl;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  team_06_echo_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  team_06_echo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM responder and monitors, evaluated on the falling edge.
  int      ack_delay = 0;
  bit      ram_en = 1'b1;
  bit      force_ack = 1'b0;
  int      wait_cnt = 0;
  logic [DW-1:0] ram [0:DEPTH-1];
  int      wr_a[$];
  int      wr_d[$];
  int      rd_a[$];
  int      se_cyc[$];
  int      ovr_cnt = 0;
  int      unstable = 0;
  logic    cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;

  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;

  always @(negedge clk) begin
    bus.mem_ack = force_ack;
    if (bus.search_enable === 1'b1) se_cyc.push_back(cyc + 1);
    if (bus.overrun === 1'b1) ovr_cnt++;
    if (ram_en && bus.mem_req === 1'b1) begin
      if (wait_cnt == 0) begin
        cap_we = bus.mem_we; cap_addr = bus.mem_addr; cap_wdata = bus.mem_wdata;
      end else if (bus.mem_we !== cap_we || bus.mem_addr !== cap_addr || bus.mem_wdata !== cap_wdata) begin
        unstable++;
      end
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack = 1'b1;
        wait_cnt = 0;
        if (bus.mem_we) begin
          ram[bus.mem_addr] = bus.mem_wdata;
          wr_a.push_back(int'(bus.mem_addr));
          wr_d.push_back(int'(bus.mem_wdata));
        end else begin
          bus.mem_rdata = ram[bus.mem_addr];
          rd_a.push_back(int'(bus.mem_addr));
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick(input int s, input bit srch, input int off, output int n);
    @(negedge clk);
    bus.sample_tick = 1'b1;
    bus.save_audio  = DW'(s);
    bus.search      = srch;
    bus.offset      = AW'(off);
    n = cyc + 1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (bus.busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle"}, int'(bus.busy), 0);
  endtask

  typedef struct {
    int save; bit srch; int off;
    int exp_wa; int exp_nrd; int exp_ra; int exp_past; int exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, wb, rb, sb, ob, ub;
    string nm;

    bus.sample_tick = 1'b0; bus.search = 1'b0; bus.offset = '0; bus.save_audio = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;

    vecs[0] = '{68, 1'b0, 0,  0, 0, 0, 0,  0};
    vecs[1] = '{78, 1'b0, 0,  1, 0, 0, 0,  0};
    vecs[2] = '{75, 1'b0, 0,  2, 0, 0, 0,  0};
    vecs[3] = '{65, 1'b1, 2,  3, 1, 1, 78, 3};
    vecs[4] = '{99, 1'b1, 50, 4, 0, 0, 0,  2};
    vecs[5] = '{12, 1'b1, 0,  5, 0, 0, 0,  2};
    vecs[6] = '{33, 1'b1, 6,  6, 1, 0, 68, 3};
    vecs[7] = '{44, 1'b1, 8,  7, 0, 0, 0,  2};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", int'(bus.mem_req), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_search_enable", int'(bus.search_enable), 0);
    chk("rst_past_output", int'(bus.past_output), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    rst = 1'b0;

    // Asynchronous reset in the middle of an unacknowledged write
    ram_en = 1'b0;
    do_tick(17, 1'b1, 1, n);
    @(negedge clk);
    chk("midwr_req_before_rst", int'(bus.mem_req), 1);
    #2 rst = 1'b1;
    #1;
    chk("midwr_req_async_drop", int'(bus.mem_req), 0);
    chk("midwr_we", int'(bus.mem_we), 0);
    chk("midwr_addr", int'(bus.mem_addr), 0);
    chk("midwr_wdata", int'(bus.mem_wdata), 0);
    chk("midwr_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_ack_req", int'(bus.mem_req), 0);
    chk("stray_ack_busy", int'(bus.busy), 0);
    chk("stray_ack_se", se_cyc.size(), 0);
    ram_en = 1'b1;

    // Table of single-tick transactions, immediate ack
    for (int v = 0; v < 8; v++) begin
      nm = $sformatf("vec%0d", v);
      wb = wr_a.size(); rb = rd_a.size(); sb = se_cyc.size(); ob = ovr_cnt;
      do_tick(vecs[v].save, vecs[v].srch, vecs[v].off, n);
      repeat (8) @(negedge clk);
      wait_idle(nm);
      chk({nm, "_nwr"}, wr_a.size() - wb, 1);
      chk({nm, "_wr_addr"}, (wr_a.size() > wb) ? wr_a[wb] : -1, vecs[v].exp_wa);
      chk({nm, "_wr_data"}, (wr_d.size() > wb) ? wr_d[wb] : -1, vecs[v].save);
      chk({nm, "_nrd"}, rd_a.size() - rb, vecs[v].exp_nrd);
      if (vecs[v].exp_nrd == 1)
        chk({nm, "_rd_addr"}, (rd_a.size() > rb) ? rd_a[rb] : -1, vecs[v].exp_ra);
      chk({nm, "_nse"}, se_cyc.size() - sb, (vecs[v].exp_lat != 0) ? 1 : 0);
      if (vecs[v].exp_lat != 0)
        chk({nm, "_se_cycle"}, (se_cyc.size() > sb) ? se_cyc[sb] - n : -1, vecs[v].exp_lat);
      chk({nm, "_past"}, int'(bus.past_output), vecs[v].exp_past);
      chk({nm, "_overrun"}, ovr_cnt - ob, 0);
    end

    // Four-cycle ack stalls with a second tick dropped during READ
    ack_delay = 4;
    wb = wr_a.size(); rb = rd_a.size(); sb = se_cyc.size(); ob = ovr_cnt; ub = unstable;
    do_tick(55, 1'b1, 3, n);
    while (cyc + 1 < n + 6) @(negedge clk);
    bus.sample_tick = 1'b1; bus.save_audio = 8'hEE; bus.search = 1'b1; bus.offset = AW'(1);
    @(negedge clk);
    bus.sample_tick = 1'b0;
    repeat (10) @(negedge clk);
    wait_idle("stall");
    chk("stall_nwr", wr_a.size() - wb, 1);
    chk("stall_wr_addr", (wr_a.size() > wb) ? wr_a[wb] : -1, 8);
    chk("stall_wr_data", (wr_d.size() > wb) ? wr_d[wb] : -1, 55);
    chk("stall_rd_addr", (rd_a.size() > rb) ? rd_a[rb] : -1, 5);
    chk("stall_se_cycle", (se_cyc.size() > sb) ? se_cyc[sb] - n : -1, 11);
    chk("stall_past", int'(bus.past_output), 12);
    chk("stall_overrun_pulses", ovr_cnt - ob, 1);
    chk("stall_req_stable", unstable - ub, 0);
    ack_delay = 0;

    // Wrap-around: fill 8191 slots, then write at 8191 and read 8188
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    wb = wr_a.size(); ob = ovr_cnt;
    for (int k = 0; k < DEPTH - 1; k++) begin
      @(negedge clk);
      bus.sample_tick = 1'b1; bus.save_audio = DW'(k); bus.search = 1'b0; bus.offset = '0;
      @(negedge clk);
      bus.sample_tick = 1'b0;
    end
    wait_idle("preload");
    chk("preload_nwr", wr_a.size() - wb, DEPTH - 1);
    chk("preload_last_addr", wr_a[wr_a.size() - 1], DEPTH - 2);
    chk("preload_overrun", ovr_cnt - ob, 0);
    wb = wr_a.size(); rb = rd_a.size(); sb = se_cyc.size();
    do_tick(255, 1'b1, 3, n);
    repeat (6) @(negedge clk);
    wait_idle("wrap");
    chk("wrap_wr_addr", (wr_a.size() > wb) ? wr_a[wb] : -1, 8191);
    chk("wrap_rd_addr", (rd_a.size() > rb) ? rd_a[rb] : -1, 8188);
    chk("wrap_past", int'(bus.past_output), 252);
    chk("wrap_se_cycle", (se_cyc.size() > sb) ? se_cyc[sb] - n : -1, 3);
    wb = wr_a.size();
    do_tick(7, 1'b0, 0, n);
    repeat (4) @(negedge clk);
    wait_idle("post_wrap");
    chk("post_wrap_wr_addr", (wr_a.size() > wb) ? wr_a[wb] : -1, 0);
    chk("post_wrap_wr_data", (wr_d.size() > wb) ? wr_d[wb] : -1, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/team_06_echo_ctrl.md
# team_06_echo_ctrl

Sequencer and delay-memory controller for the echo effect datapath. On each audio sample strobe it stores the effect's `save_audio` sample into a circular delay buffer in external sample RAM. When the effect requests a past sample, it fetches the sample `offset` positions back and presents it on `past_output` with a one-cycle `search_enable` strobe. It sits between the echo effect and the shared sample RAM port, and owns the write pointer, the fill level and the RAM request handshake.

## Interface
- `ADDR_W`, 13: delay buffer address width; buffer depth is 2^ADDR_W samples.
- `DATA_W`, 8: sample width.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sample_tick` in 1: one-cycle strobe marking a new audio sample.
- `search` in 1: effect requests a past sample for this tick; sampled with `sample_tick`.
- `offset` in ADDR_W: delay in samples; sampled with `sample_tick`.
- `save_audio` in DATA_W: sample to store; sampled with `sample_tick`.
- `past_output` out DATA_W: fetched past sample; holds until the next fetch.
- `search_enable` out 1: one-cycle strobe; `past_output` is valid this cycle.
- `mem_req` out 1: RAM request; held until `mem_ack`.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data; valid in the `mem_ack` cycle of a read.
- `mem_ack` in 1: one-cycle acknowledge. Completes the request in the same cycle.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: one-cycle pulse when a `sample_tick` is dropped.

## Operation
- Registers:
  - `wr_ptr` (ADDR_W): wraps from 2^ADDR_W−1 to 0.
  - `fill` (ADDR_W): samples stored; saturates at 2^ADDR_W−1.
  - Latched copies of `search`, `offset` and `save_audio`.
- States IDLE, WRITE, READ, DONE.
- IDLE:
  - On `sample_tick`, latch the inputs and go to WRITE.
  - `mem_ack` is ignored in IDLE.
- WRITE:
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr`=`wr_ptr`, `mem_wdata`=latched sample.
  - On `mem_ack`:
    - Compute `rd_addr` = (`wr_ptr` − latched `offset`) mod 2^ADDR_W, using the pre-increment pointer.
    - Then `wr_ptr`+1 and `fill`+1 (saturating).
  - If latched `search`=0, go to IDLE.
  - Else if latched `offset`=0 or `offset` > `fill` (pre-increment), load `past_output`=0 and go to DONE. Unfilled history reads as silence.
  - Else go to READ.
- READ:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=`rd_addr`.
  - On `mem_ack`, load `past_output`=`mem_rdata` and go to DONE.
- DONE: `search_enable`=1 for exactly one cycle, then IDLE.
- Arithmetic: pointer subtraction and increment are modulo 2^ADDR_W with no extra carry bit. `fill` never wraps.
- Overrun:
  - A `sample_tick` while `busy`=1 is dropped.
  - `overrun` pulses the following cycle.
  - Latched inputs and pointers are unaffected.
- When `mem_req`=0, `mem_we`, `mem_addr` and `mem_wdata` are 0.

## Timing
- Reset values:
  - All outputs 0.
  - `wr_ptr`=0, `fill`=0, state IDLE.
- Reset asserted mid-transaction:
  - `mem_req` drops asynchronously.
  - Any acknowledge arriving after reset release is ignored (IDLE).
- Latency with `mem_ack` in the first request cycle:
  - Tick sampled at edge n.
  - WRITE request during cycle n+1.
  - READ request during cycle n+2.
  - `search_enable` high during cycle n+3.
  - Each cycle `mem_ack` is withheld adds one cycle.
- Zero-fill path (offset 0 or too large): `search_enable` during cycle n+2.
- `search`=0 path: `busy` high for cycle n+1 only, assuming an immediate ack.
- A tick arriving in the same cycle as the DONE→IDLE transition is dropped (state is DONE). A tick on the first IDLE cycle is accepted.
- `mem_req`, `mem_we` and `mem_addr` are stable while waiting for `mem_ack`.

## Test plan
- Reset with `rst`=1 asserted asynchronously mid-WRITE → `mem_req` falls before the next clock edge; all outputs 0; after release, `wr_ptr`=0.
- Ticks with samples 68, 78, 75, `search`=0, RAM acking immediately → writes to addresses 0, 1, 2 with data 68, 78, 75; no `search_enable` pulse.
- After the previous scenario, tick with sample 65, `search`=1, `offset`=2 → write 65 at address 3, then read address 1; `past_output`=78 with `search_enable` at n+3.
- `offset`=50 with `fill`=4 → no read issued; `past_output`=0 and `search_enable` at n+2.
- Wrap-around:
  - Preload `wr_ptr`=8191 by writing 8191 samples, with sample k = k mod 256.
  - Tick with `offset`=3.
  - Expect a write at 8191, a read at 8188, and `past_output`=8188 mod 256=252.
  - The next write goes to address 0.
- RAM holds `mem_ack` off for 4 cycles on each request, and a second tick arrives during READ → request signals stay stable; `search_enable` at n+11; `overrun` pulses once; the second sample is never written.
